// File: rtl/spi_reg_slave.sv
// spi_reg_slave
//   SPI (mode 0, MSB first) slave that bridges STM frames onto a simple
//   register bus. A frame is: ADDR_W address bits (MSB = read flag), then
//   DUMMY_CYCLES ignored clocks, then DATA_W data bits. Writes produce a
//   one-cycle bus_we; reads issue a one-cycle bus_re on entering the dummy
//   phase and shift the returned word out on spi_miso.
//   All SPI inputs are oversampled in the sys_clk domain.
//
// Ports
//   sys_clk, sys_rst      : clock, synchronous active-high reset
//   spi_clk, spi_mosi,
//   spi_cs_n              : asynchronous SPI inputs
//   spi_miso              : serial read data out
//   bus_addr              : register address (frame address minus read flag)
//   bus_we, bus_wdata     : single-cycle write strobe and its data
//   bus_re, bus_rdata     : single-cycle read strobe; data due one cycle later
//   frame_abort           : single-cycle pulse when cs_n ends a frame early
module spi_reg_slave #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic [ADDR_W-2:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              frame_abort
);

  localparam int MAX_AD   = (ADDR_W > DUMMY_CYCLES) ? ADDR_W : DUMMY_CYCLES;
  localparam int MAX_BITS = (MAX_AD > DATA_W) ? MAX_AD : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA
  } state_t;

  // Synchronizer chains: bit 0 is the newest sample, MSB is the usable one.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  // Marks when the chains have flushed their reset values after sys_rst.
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic [SYNC_STAGES:0]   sck_chain, mosi_chain, csn_chain, settle_chain;

  logic sck_s, mosi_s, csn_s, settled;
  logic sck_prev_q, sck_prev_d;
  logic sck_rise;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic              rd_flag_q, rd_flag_d;
  logic              rd_lat_q, rd_lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] shout_q, shout_d;
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] data_shift;

  logic              miso_q, miso_d;
  logic [ADDR_W-2:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_re_q, bus_re_d;
  logic              frame_abort_q, frame_abort_d;

  always_comb begin
    sck_chain    = {sck_sync_q, spi_clk};
    mosi_chain   = {mosi_sync_q, spi_mosi};
    csn_chain    = {csn_sync_q, spi_cs_n};
    settle_chain = {settle_q, 1'b1};
    sck_sync_d   = sck_chain[SYNC_STAGES-1:0];
    mosi_sync_d  = mosi_chain[SYNC_STAGES-1:0];
    csn_sync_d   = csn_chain[SYNC_STAGES-1:0];
    settle_d     = settle_chain[SYNC_STAGES-1:0];
  end

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s      = csn_sync_q[SYNC_STAGES-1];
  assign settled    = settle_q[SYNC_STAGES-1];
  assign sck_prev_d = sck_s;
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
  assign data_shift = {data_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    rd_flag_d     = rd_flag_q;
    rd_lat_d      = bus_re_q;
    addr_d        = addr_q;
    data_d        = data_q;
    shout_d       = shout_q;
    bus_addr_d    = bus_addr_q;
    bus_we_d      = 1'b0;
    bus_wdata_d   = bus_wdata_q;
    bus_re_d      = 1'b0;
    frame_abort_d = 1'b0;

    // Read data arrives the cycle after bus_re is seen by the register bus.
    if (rd_lat_q) begin
      shout_d = bus_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        // A frame may only start after cs_n has been seen high, so the tail
        // of a finished, aborted or reset-interrupted frame is ignored.
        // The settle gate keeps the reset value of the cs_n chain from
        // arming mid-frame.
        if (armed_q && !csn_s) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else if (settled && csn_s) begin
          armed_d = 1'b1;
        end
      end

      ST_ADDR: begin
        if (csn_s) begin
          state_d       = ST_IDLE;
          frame_abort_d = 1'b1;
        end else if (sck_rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            state_d    = ST_DUMMY;
            cnt_d      = '0;
            bus_addr_d = addr_shift[ADDR_W-2:0];
            rd_flag_d  = addr_shift[ADDR_W-1];
            bus_re_d   = addr_shift[ADDR_W-1];
            if (!addr_shift[ADDR_W-1]) begin
              shout_d = '0;
            end
          end
        end
      end

      ST_DUMMY: begin
        if (csn_s) begin
          state_d       = ST_IDLE;
          frame_abort_d = 1'b1;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
      end

      ST_DATA: begin
        if (csn_s) begin
          state_d       = ST_IDLE;
          frame_abort_d = 1'b1;
        end else if (sck_rise) begin
          data_d = data_shift;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!rd_flag_q) begin
              bus_we_d    = 1'b1;
              bus_wdata_d = data_shift;
            end
          end else begin
            // Next bit must be on miso well before the master's next fall.
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // miso is registered from the next-state values so the MSB appears in
    // the same cycle DATA is entered and drops to 0 as soon as it is left.
    miso_d = (state_d == ST_DATA) ? shout_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      csn_sync_q    <= '1;
      settle_q      <= '0;
      sck_prev_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      rd_flag_q     <= 1'b0;
      rd_lat_q      <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      shout_q       <= '0;
      miso_q        <= 1'b0;
      bus_addr_q    <= '0;
      bus_we_q      <= 1'b0;
      bus_wdata_q   <= '0;
      bus_re_q      <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      csn_sync_q    <= csn_sync_d;
      settle_q      <= settle_d;
      sck_prev_q    <= sck_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      rd_flag_q     <= rd_flag_d;
      rd_lat_q      <= rd_lat_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      shout_q       <= shout_d;
      miso_q        <= miso_d;
      bus_addr_q    <= bus_addr_d;
      bus_we_q      <= bus_we_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_re_q      <= bus_re_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign spi_miso    = miso_q;
  assign bus_addr    = bus_addr_q;
  assign bus_we      = bus_we_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_re      = bus_re_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave
//   Drives SPI frames into spi_reg_slave, plays the register bus with a
//   memory, and checks strobes, addresses and shifted-out read data against
//   a reference register file maintained directly from the issued frames.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int HALF = 60;  // SPI half period in ns (sys_clk is 10 ns)

  logic        sys_clk;
  logic        sys_rst;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_miso;
  logic [6:0]  bus_addr;
  logic        bus_we;
  logic [15:0] bus_wdata;
  logic        bus_re;
  logic [15:0] bus_rdata;
  logic        frame_abort;

  spi_reg_slave #(
    .ADDR_W(8), .DATA_W(16), .DUMMY_CYCLES(8), .SYNC_STAGES(2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_miso   (spi_miso),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .frame_abort(frame_abort)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference register file (what the frames should have stored) and the
  // register file seen from the bus side (what the DUT actually wrote).
  logic [15:0] ref_mem [128];
  logic [15:0] bus_mem [128];

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          ab_cnt = 0;
  int          rd_hold = 0;
  logic [6:0]  last_we_addr = '0;
  logic [15:0] last_we_data = '0;
  logic [6:0]  last_re_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus-side monitor and read responder: read data is valid the cycle after
  // bus_re and is randomised otherwise.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus_we) begin
        we_cnt++;
        last_we_addr = bus_addr;
        last_we_data = bus_wdata;
        bus_mem[bus_addr] = bus_wdata;
      end
      if (frame_abort) ab_cnt++;
    end
    if (!sys_rst && bus_re) begin
      re_cnt++;
      last_re_addr = bus_addr;
      bus_rdata = bus_mem[bus_addr];
      rd_hold = 2;
    end else if (rd_hold > 0) begin
      rd_hold--;
      if (rd_hold == 0) bus_rdata = 16'($urandom);
    end
  end

  task automatic spi_xfer(input logic [7:0] a, input logic [15:0] d, input int nbits,
                          input bit rst_mid, output logic [15:0] rb, output bit leak);
    logic [31:0] stream;
    stream = {a, 8'($urandom), d};
    rb = '0;
    leak = 1'b0;
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      if (rst_mid && i == 12) begin
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
      end
      spi_mosi = stream[31-i];
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      // Master samples miso just before each falling edge.
      if (i >= 15 && i <= 30) rb = {rb[14:0], spi_miso};
      else if (spi_miso !== 1'b0) leak = 1'b1;
      spi_clk = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(4*HALF);  // cs_n high for two SPI periods between frames
  endtask

  task automatic run_frame(input bit rd, input logic [6:0] a, input logic [15:0] d,
                           input int nbits, input bit rst_mid);
    int we0, re0, ab0;
    logic [15:0] rb;
    bit leak;
    we0 = we_cnt;
    re0 = re_cnt;
    ab0 = ab_cnt;
    spi_xfer({rd, a}, d, nbits, rst_mid, rb, leak);
    $display("[%0t] frame %s addr=%02h wdata=%04h bits=%0d rst=%0d rx=%04h", $time,
             rd ? "RD" : "WR", a, d, nbits, rst_mid, rb);
    chk("miso_outside_data", 32'(leak), 32'd0);
    if (rst_mid) begin
      chk("rst_no_we", we_cnt - we0, 0);
      chk("rst_no_abort", ab_cnt - ab0, 0);
    end else if (nbits < 32) begin
      chk("abort_no_we", we_cnt - we0, 0);
      chk("abort_pulse", ab_cnt - ab0, 1);
    end else begin
      chk("no_abort", ab_cnt - ab0, 0);
      if (rd) begin
        chk("re_count", re_cnt - re0, 1);
        chk("re_addr", 32'(last_re_addr), 32'(a));
        chk("no_we_on_read", we_cnt - we0, 0);
        chk("read_data", 32'(rb), 32'(ref_mem[a]));
      end else begin
        chk("we_count", we_cnt - we0, 1);
        chk("we_addr", 32'(last_we_addr), 32'(a));
        chk("we_data", 32'(last_we_data), 32'(d));
        chk("no_re_on_write", re_cnt - re0, 0);
        ref_mem[a] = d;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pats [4];
    logic [15:0] v;
    pats[0] = 16'h0001; pats[1] = 16'h8000; pats[2] = 16'hFFFF; pats[3] = 16'h0000;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      ref_mem[i] = v;
      bus_mem[i] = v;
    end
    sys_rst   = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_cs_n  = 1'b1;
    bus_rdata = '0;
    repeat (5) @(negedge sys_clk);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_re", 32'(bus_re), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", 32'(bus_wdata), 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Basic write, then read of a preset register.
    run_frame(1'b0, 7'h00, 16'hAAAA, 32, 1'b0);
    ref_mem[1] = 16'h5555;
    bus_mem[1] = 16'h5555;
    run_frame(1'b1, 7'h01, 16'h0000, 32, 1'b0);

    // Walking edge patterns written then read back.
    for (int p = 0; p < 4; p++) begin
      run_frame(1'b0, 7'h00, pats[p], 32, 1'b0);
      run_frame(1'b1, 7'h00, 16'h0000, 32, 1'b0);
    end

    // Abort after 10 data bits, then normal traffic.
    run_frame(1'b0, 7'h05, 16'h1234, 26, 1'b0);
    run_frame(1'b1, 7'h05, 16'h0000, 32, 1'b0);
    run_frame(1'b0, 7'h05, 16'h1234, 32, 1'b0);
    run_frame(1'b1, 7'h05, 16'h0000, 32, 1'b0);

    // Reset during the dummy phase of a write, then normal traffic.
    run_frame(1'b0, 7'h22, 16'hBEEF, 32, 1'b1);
    run_frame(1'b1, 7'h22, 16'h0000, 32, 1'b0);
    run_frame(1'b0, 7'h22, 16'hC0DE, 32, 1'b0);
    run_frame(1'b1, 7'h22, 16'h0000, 32, 1'b0);

    // Back-to-back writes with minimum gap, checked in order.
    run_frame(1'b0, 7'h10, 16'h0F0F, 32, 1'b0);
    run_frame(1'b0, 7'h11, 16'hF0F0, 32, 1'b0);
    run_frame(1'b1, 7'h10, 16'h0000, 32, 1'b0);
    run_frame(1'b1, 7'h11, 16'h0000, 32, 1'b0);

    // Randomised traffic over a small address window to force reuse.
    for (int n = 0; n < 24; n++) begin
      run_frame(1'($urandom), 7'($urandom_range(0, 7)), 16'($urandom), 32, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning frame address field width (MSB = read flag).
REQ-002 SHALL have parameter DATA_W, default 16, meaning frame data field width.
REQ-003 SHALL have parameter DUMMY_CYCLES, default 8, meaning spi_clk cycles between the address and data fields.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_clk, spi_mosi and spi_cs_n.
REQ-005 SHALL have port sys_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1, reset; one clock, synchronous, active-high.
REQ-007 SHALL have port spi_clk, input, 1, SPI clock from the STM, idle low, asynchronous to sys_clk.
REQ-008 SHALL have port spi_mosi, input, 1, serial data in, MSB first.
REQ-009 SHALL have port spi_cs_n, input, 1, active-low frame select.
REQ-010 SHALL have port spi_miso, output, 1, serial read data out, MSB first.
REQ-011 SHALL have port bus_addr, output, ADDR_W-1, register address (frame address without read flag).
REQ-012 SHALL have port bus_we, output, 1, single-cycle write strobe.
REQ-013 SHALL have port bus_wdata, output, DATA_W, write data, valid while bus_we is high.
REQ-014 SHALL have port bus_re, output, 1, single-cycle read strobe.
REQ-015 SHALL have port bus_rdata, input, DATA_W, register read data, valid exactly 1 cycle after bus_re.
REQ-016 SHALL have port frame_abort, output, 1, single-cycle pulse when a frame ends before completion.

Function
REQ-017 SHALL pass spi_clk, spi_mosi and spi_cs_n through SYNC_STAGES-deep flop chains; all decisions use only the synchronized values.
REQ-018 SHALL detect an SCK rise as synchronized spi_clk = 1 with previous value 0, and SCK fall analogously.
REQ-019 SHALL implement states IDLE, ADDR, DUMMY and DATA, with a bit counter sized for max(ADDR_W, DUMMY_CYCLES, DATA_W).
REQ-020 SHALL leave IDLE for ADDR on the cycle in which synchronized cs_n is low, clearing the bit counter.
REQ-021 SHALL shift synchronized mosi into the address register on each SCK rise in ADDR, and move to DUMMY after ADDR_W rises.
REQ-022 SHALL, on entry to DUMMY with read flag = 1, drive bus_addr and pulse bus_re for 1 cycle, then latch bus_rdata into the shift-out register on the following cycle.
REQ-023 SHALL drive bus_addr, without a read strobe, on entry to DUMMY for write frames.
REQ-024 SHALL count DUMMY_CYCLES SCK rises in DUMMY and then move to DATA, presenting shift-out register MSB on spi_miso in the same cycle.
REQ-025 SHALL, in DATA, shift mosi in on each SCK rise, and after each rise except the last shift the out-register left so the next bit is on spi_miso before the next SCK fall.
REQ-026 SHALL, on the DATA_W-th rise of a write frame, pulse bus_we 1 cycle later with bus_wdata = the DATA_W captured bits, then return to IDLE.
REQ-027 SHALL, on the DATA_W-th rise of a read frame, issue no bus_we and return to IDLE.
REQ-028 SHALL drive spi_miso = 0 in IDLE, ADDR and DUMMY.
REQ-029 SHALL, if synchronized cs_n goes high in ADDR, DUMMY or DATA before completion, return to IDLE, issue no bus_we and pulse frame_abort 1 cycle.
REQ-030 SHALL ignore SCK edges while cs_n is high, and SHALL wait in IDLE until cs_n is high again before arming a new frame.
REQ-031 SHALL require sys_clk >= 6x spi_clk frequency and DUMMY_CYCLES >= 1; behaviour outside this range is undefined.

Reset
REQ-032 SHALL, while sys_rst is high, force state IDLE, all counters and shift registers 0, synchronizers to the idle values (spi_clk 0, cs_n 1), and bus_we, bus_re, frame_abort, spi_miso, bus_addr and bus_wdata to 0.
REQ-033 SHALL, on reset mid-frame, discard the frame with no bus_we or frame_abort, and treat the remainder of that cs_n-low period as ignored (REQ-030).

Verification
REQ-034 SHALL pass: write frame addr 0x00, data 0xAAAA -> exactly one bus_we with bus_addr 0x00 and bus_wdata 0xAAAA.
REQ-035 SHALL pass: read frame addr 0x81 with bus_rdata model 0x5555 -> one bus_re with bus_addr 0x01, spi_miso data bits sampled at SCK falls = 0x5555, no bus_we.
REQ-036 SHALL pass: patterns 0x0001, 0x8000, 0xFFFF and 0x0000 written then read back at addr 0x00 -> readback equals write in each case.
REQ-037 SHALL pass: cs_n raised after 10 data bits of write 0x1234 -> no bus_we and one frame_abort pulse; the next full frame works normally.
REQ-038 SHALL pass: sys_rst pulsed during DUMMY of a write frame -> no bus_we, and the next frame after cs_n high decodes correctly.
REQ-039 SHALL pass: back-to-back frames with cs_n high for 2 SPI periods -> both frames decode and issue their strobes in order.
